// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus interface.
// Groups the core-side instruction handshake, the branch redirect inputs and
// the instruction-memory req/ack bus into one bundle.
//   master : the fetch unit (drives instr_*, mem_req, mem_addr, busy)
//   slave  : the environment, i.e. core plus memory (drives redirect*,
//            instr_ready, mem_ack, mem_rdata)
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    input  redirect, redirect_pc, instr_ready, mem_ack, mem_rdata,
    output instr_valid, instr_out, instr_pc, mem_req, mem_addr, busy
  );

  modport slave (
    output redirect, redirect_pc, instr_ready, mem_ack, mem_rdata,
    input  instr_valid, instr_out, instr_pc, mem_req, mem_addr, busy
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end.
// Owns the fetch PC, issues one outstanding word read at a time to a
// variable-latency memory, buffers returned words in a DEPTH-entry prefetch
// FIFO and presents the head entry to the core. A redirect flushes the FIFO
// and re-steers fetching; an access already in flight is allowed to finish
// and its data is dropped.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : instr_fetch_unit_if master modport (core + memory signals)
module instr_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [DATA_W-1:0] fifo_word_q [DEPTH];

  logic              push;
  logic              pop;
  logic              flush;
  logic              head_valid;
  logic [CNT_W-1:0]  count_after;
  logic [ADDR_W-1:0] next_addr;

  assign head_valid = (count_q != '0);
  assign next_addr  = mem_addr_q + ADDR_W'(4);

  // Fetch control. Redirect always wins: the FIFO is flushed and nothing is
  // pushed or popped that cycle. A request, once raised, is never withdrawn
  // before its ack, so a redirect during an access parks in S_DROP until the
  // stale word comes back.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    push        = 1'b0;
    flush       = 1'b0;
    pop         = head_valid && bus.instr_ready && !bus.redirect;
    count_after = count_q + CNT_W'(1) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_d = bus.redirect_pc;
        end else if (count_q < FULL_CNT) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_d = bus.redirect_pc;
          if (bus.mem_ack) begin
            mem_addr_d = bus.redirect_pc;
          end else begin
            state_d = S_DROP;
          end
        end else if (bus.mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = next_addr;
          if (count_after < FULL_CNT) begin
            mem_addr_d = next_addr;
          end else begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_d = bus.redirect_pc;
        end
        if (bus.mem_ack) begin
          mem_addr_d = bus.redirect ? bus.redirect_pc : fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
      fifo_word_q[wr_ptr_q] <= bus.mem_rdata;
    end
  end

  // Head is gated so an empty FIFO presents zeros rather than stale entries.
  assign bus.instr_valid = head_valid;
  assign bus.instr_out   = head_valid ? fifo_word_q[rd_ptr_q] : '0;
  assign bus.instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit.
// Directed cycle tables for the start-up, back-pressure, redirect and reset
// corner cases, followed by a randomized run checked against a stream-level
// reference: delivered instructions must be consecutive words from the most
// recent redirect target, each carrying the memory's word for its address.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Contents of the modelled instruction memory.
  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic void add(input logic rst, input logic redir, input logic [31:0] rpc,
                              input logic ready, input logic ack, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, input logic e_busy);
    vec_t v;
    v = '{rst, redir, rpc, ready, ack, e_req, e_addr, e_valid, e_pc, e_busy};
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic redir, input logic [31:0] rpc,
                                input logic ready, input logic ack);
    ifc.redirect    = redir;
    ifc.redirect_pc = rpc;
    ifc.instr_ready = ready;
    ifc.mem_ack     = ack;
    ifc.mem_rdata   = mem_func(ifc.mem_addr);
  endtask

  // Entered and left at a falling edge, with reset released on exit.
  task automatic apply_reset();
    reset = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] r;
  logic [31:0] rpc;
  logic        redir, ready, ack;
  logic        prev_redir, prev_req, prev_ack;
  logic [31:0] prev_addr;
  int          delivered;

  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // rst redir rpc ready ack | req addr valid pc busy
    // Zero-wait streaming from reset.
    add(1,0,32'h0,  1,0, 0,32'h0,  0,32'h0,  0);
    add(0,0,32'h0,  1,1, 1,32'h0,  0,32'h0,  1);
    add(0,0,32'h0,  1,1, 1,32'h4,  1,32'h0,  1);
    add(0,0,32'h0,  1,1, 1,32'h8,  1,32'h4,  1);
    add(0,0,32'h0,  1,1, 1,32'hC,  1,32'h8,  1);
    // Core stalled: two pushes then idle; a stray ack while idle is ignored.
    add(1,0,32'h0,  0,0, 0,32'h0,  0,32'h0,  0);
    add(0,0,32'h0,  0,1, 1,32'h0,  0,32'h0,  1);
    add(0,0,32'h0,  0,1, 1,32'h4,  1,32'h0,  1);
    add(0,0,32'h0,  0,1, 0,32'h4,  1,32'h0,  0);
    add(0,0,32'h0,  1,0, 0,32'h4,  1,32'h0,  0);
    add(0,0,32'h0,  1,0, 0,32'h4,  1,32'h4,  0);
    add(0,0,32'h0,  1,1, 1,32'h8,  0,32'h0,  1);
    add(0,0,32'h0,  1,1, 1,32'hC,  1,32'h8,  1);
    // Three-cycle memory, redirect during the second wait cycle.
    add(1,0,32'h0,  1,0, 0,32'h0,  0,32'h0,  0);
    add(0,0,32'h0,  1,0, 1,32'h0,  0,32'h0,  1);
    add(0,1,32'h100,1,0, 1,32'h0,  0,32'h0,  1);
    add(0,0,32'h0,  1,1, 1,32'h0,  0,32'h0,  1);
    add(0,0,32'h0,  1,0, 1,32'h100,0,32'h0,  1);
    add(0,0,32'h0,  1,0, 1,32'h100,0,32'h0,  1);
    add(0,0,32'h0,  1,1, 1,32'h100,0,32'h0,  1);
    add(0,0,32'h0,  1,0, 1,32'h104,1,32'h100,1);
    // Redirect coinciding with the ack for 0x8.
    add(1,0,32'h0,  1,0, 0,32'h0,  0,32'h0,  0);
    add(0,0,32'h0,  1,1, 1,32'h0,  0,32'h0,  1);
    add(0,0,32'h0,  1,1, 1,32'h4,  1,32'h0,  1);
    add(0,1,32'h200,1,1, 1,32'h8,  1,32'h4,  1);
    add(0,0,32'h0,  1,1, 1,32'h200,0,32'h0,  1);
    add(0,0,32'h0,  1,0, 1,32'h204,1,32'h200,1);
    // Full FIFO, pop and redirect together.
    add(1,0,32'h0,  0,0, 0,32'h0,  0,32'h0,  0);
    add(0,0,32'h0,  0,1, 1,32'h0,  0,32'h0,  1);
    add(0,0,32'h0,  0,1, 1,32'h4,  1,32'h0,  1);
    add(0,1,32'h40, 1,0, 0,32'h4,  1,32'h0,  0);
    add(0,0,32'h0,  1,0, 0,32'h4,  0,32'h0,  0);
    add(0,0,32'h0,  1,1, 1,32'h40, 0,32'h0,  1);
    add(0,0,32'h0,  1,0, 1,32'h44, 1,32'h40, 1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) apply_reset();
      check_output($sformatf("row%0d mem_req", i), 32'(ifc.mem_req), 32'(vecs[i].e_req));
      check_output($sformatf("row%0d mem_addr", i), ifc.mem_addr, vecs[i].e_addr);
      check_output($sformatf("row%0d instr_valid", i), 32'(ifc.instr_valid), 32'(vecs[i].e_valid));
      check_output($sformatf("row%0d busy", i), 32'(ifc.busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_valid) begin
        check_output($sformatf("row%0d instr_pc", i), ifc.instr_pc, vecs[i].e_pc);
        check_output($sformatf("row%0d instr_out", i), ifc.instr_out, mem_func(vecs[i].e_pc));
      end else if (vecs[i].rst) begin
        check_output($sformatf("row%0d instr_out rst", i), ifc.instr_out, 32'h0);
        check_output($sformatf("row%0d instr_pc rst", i), ifc.instr_pc, 32'h0);
      end
      apply_stimulus(vecs[i].redir, vecs[i].rpc, vecs[i].ready, vecs[i].ack);
      @(negedge clk);
    end

    // Asynchronous reset mid-access with one entry buffered.
    apply_reset();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check_output("pre-reset instr_valid", 32'(ifc.instr_valid), 32'h1);
    check_output("pre-reset mem_req", 32'(ifc.mem_req), 32'h1);
    reset = 1'b0;
    #1;
    check_output("async mem_req", 32'(ifc.mem_req), 32'h0);
    check_output("async mem_addr", ifc.mem_addr, 32'h0);
    check_output("async instr_valid", 32'(ifc.instr_valid), 32'h0);
    check_output("async instr_out", ifc.instr_out, 32'h0);
    check_output("async instr_pc", ifc.instr_pc, 32'h0);
    check_output("async busy", 32'(ifc.busy), 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("release mem_req", 32'(ifc.mem_req), 32'h1);
    check_output("release mem_addr", ifc.mem_addr, 32'h0);
    check_output("release instr_valid", 32'(ifc.instr_valid), 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    check_output("release first pc", ifc.instr_pc, 32'h0);
    check_output("release first word", ifc.instr_out, mem_func(32'h0));
    check_output("release next addr", ifc.mem_addr, 32'h4);

    // Randomized run against the stream reference.
    apply_reset();
    exp_pc     = 32'h0;
    prev_redir = 1'b0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = 32'h0;
    delivered  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_redir)
        check_output("post-redirect instr_valid", 32'(ifc.instr_valid), 32'h0);
      if (prev_req && !prev_ack) begin
        check_output("held mem_req", 32'(ifc.mem_req), 32'h1);
        check_output("held mem_addr", ifc.mem_addr, prev_addr);
      end
      r     = $urandom;
      redir = (r[4:0] == 5'd0);
      rpc   = (r[13:10] == 4'd0) ? 32'hFFFF_FFF0 : {22'd0, r[9:2], 2'b00};
      ready = r[5] | r[6];
      ack   = ifc.mem_req ? r[7] : (r[9:8] == 2'd0);
      apply_stimulus(redir, rpc, ready, ack);
      if (!ifc.mem_req) ifc.mem_rdata = $urandom;
      if (redir) begin
        exp_pc = rpc;
      end else if (ifc.instr_valid && ready) begin
        check_output("stream instr_pc", ifc.instr_pc, exp_pc);
        check_output("stream instr_out", ifc.instr_out, mem_func(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_redir = redir;
      prev_req   = ifc.mem_req;
      prev_ack   = ack;
      prev_addr  = ifc.mem_addr;
      @(negedge clk);
    end
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("[TB] FAIL stream progress: got %0d deliveries expected at least 200", delivered);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
